// File: rtl/seven_segment_reader_if.sv
// Seven-segment readback bundle: pins in, decoded display out.
// master drives the pins, slave is the reader.
interface seven_segment_reader_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    mode;
    logic                    clear;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    frame_valid;
    logic                    pattern_err;
    logic [IDX_W-1:0]        err_digit;

    modport master (
        output seg, an, mode, clear,
        input  value, digit_valid, frame_valid, pattern_err, err_digit
    );

    modport slave (
        input  seg, an, mode, clear,
        output value, digit_valid, frame_valid, pattern_err, err_digit
    );
endinterface

// File: rtl/seven_segment_reader.sv
// Debounces multiplexed active-low 7-seg pins and decodes them
// back into nibbles, with frame and pattern-error reporting.
module seven_segment_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    seven_segment_reader_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int N = NUM_DIGITS;

    typedef enum logic [1:0] {IDLE, COUNT, HELD} state_e;

    logic [6:0]       seg_s1_q, seg_s2_q;
    logic [N-1:0]     an_s1_q, an_s2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       st_seg_q, st_seg_d;
    logic [N-1:0]     st_an_q, st_an_d;
    logic             acc_q, acc_d;
    logic [4*N-1:0]   value_q, value_d;
    logic [N-1:0]     dv_q, dv_d;
    logic [N-1:0]     seen_q, seen_d;
    logic             fv_q, fv_d;
    logic             perr_q, perr_d;
    logic [IDX_W-1:0] edig_q, edig_d;

    logic             en_ok, same;
    logic [4:0]       dec;
    logic [IDX_W-1:0] aidx;
    logic [N-1:0]     hit;

    function automatic logic one_low(input logic [N-1:0] a);
        int n;
        n = 0;
        for (int i = 0; i < N; i++)
            if (!a[i]) n++;
        return n == 1;
    endfunction

    function automatic logic [IDX_W-1:0] low_idx(input logic [N-1:0] a);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (!a[i]) r = IDX_W'(i);
        return r;
    endfunction

    // {decodable, nibble}
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        unique case (s)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0010000: r = 5'h19;
            7'b0001000: r = 5'h1a;
            7'b0000011: r = 5'h1b;
            7'b1000110: r = 5'h1c;
            7'b0100001: r = 5'h1d;
            7'b0000110: r = 5'h1e;
            7'b0001110: r = 5'h1f;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    assign en_ok = one_low(an_s2_q);
    assign same  = {an_s2_q, seg_s2_q} == {st_an_q, st_seg_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        st_seg_d = st_seg_q;
        st_an_d  = st_an_q;
        acc_d    = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (en_ok) begin
                        state_d  = COUNT;
                        cnt_d    = CNT_W'(1);
                        st_seg_d = seg_s2_q;
                        st_an_d  = an_s2_q;
                    end
                end
                COUNT: begin
                    if (!en_ok) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (same) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                            state_d = HELD;
                            acc_d   = 1'b1;
                        end
                    end else begin
                        cnt_d    = CNT_W'(1);
                        st_seg_d = seg_s2_q;
                        st_an_d  = an_s2_q;
                    end
                end
                HELD: begin
                    if (!en_ok) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (!same) begin
                        state_d  = COUNT;
                        cnt_d    = CNT_W'(1);
                        st_seg_d = seg_s2_q;
                        st_an_d  = an_s2_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign dec  = decode(st_seg_q);
    assign aidx = low_idx(st_an_q);
    assign hit  = ~st_an_q;

    always_comb begin
        value_d = value_q;
        dv_d    = dv_q;
        seen_d  = seen_q;
        perr_d  = perr_q;
        edig_d  = edig_q;
        fv_d    = 1'b0;
        if (bus.clear) begin
            value_d = '0;
            dv_d    = '0;
            seen_d  = '0;
            perr_d  = 1'b0;
        end else if (acc_q) begin
            if (st_seg_q == 7'h7f) begin
                value_d[4*int'(aidx) +: 4] = 4'h0;
                dv_d[aidx] = 1'b0;
            end else if (dec[4] && (bus.mode || dec[3:0] < 4'ha)) begin
                value_d[4*int'(aidx) +: 4] = dec[3:0];
                dv_d[aidx] = 1'b1;
            end else begin
                perr_d = 1'b1;
                edig_d = aidx;
            end
            // Completing the mask pulses and restarts it on the same edge.
            if ((seen_q | hit) == '1) begin
                fv_d   = 1'b1;
                seen_d = '0;
            end else begin
                seen_d = seen_q | hit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            an_s1_q  <= '1;
            an_s2_q  <= '1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            st_seg_q <= '1;
            st_an_q  <= '1;
            acc_q    <= 1'b0;
            value_q  <= '0;
            dv_q     <= '0;
            seen_q   <= '0;
            fv_q     <= 1'b0;
            perr_q   <= 1'b0;
            edig_q   <= '0;
        end else begin
            seg_s1_q <= bus.seg;
            seg_s2_q <= seg_s1_q;
            an_s1_q  <= bus.an;
            an_s2_q  <= an_s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            st_seg_q <= st_seg_d;
            st_an_q  <= st_an_d;
            acc_q    <= acc_d;
            value_q  <= value_d;
            dv_q     <= dv_d;
            seen_q   <= seen_d;
            fv_q     <= fv_d;
            perr_q   <= perr_d;
            edig_q   <= edig_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.digit_valid = dv_q;
    assign bus.frame_valid = fv_q;
    assign bus.pattern_err = perr_q;
    assign bus.err_digit   = edig_q;
endmodule

// File: tb/tb_seven_segment_reader.sv
// Scoreboard bench for seven_segment_reader: run-length reference
// model predicts every cycle, a monitor process checks it.
module tb_seven_segment_reader;
    localparam int S = 4;
    localparam int N = 4;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dv;
        logic        fv;
        logic        perr;
        logic [1:0]  edig;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_segment_reader_if #(.NUM_DIGITS(N)) bus ();

    seven_segment_reader #(
        .NUM_DIGITS(N),
        .STABLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    obs_t exp_q[$];
    logic [6:0] pat [16];

    logic [10:0] m_pipe [2];
    logic [10:0] run_val;
    int          run_len;
    logic        m_pend;
    logic [10:0] m_pend_smp;
    logic [15:0] m_val;
    logic [3:0]  m_dv, m_seen;
    logic        m_fv, m_perr;
    logic [1:0]  m_edig;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe[0] = '1;
        m_pipe[1] = '1;
        run_val = '1;
        run_len = 0;
        m_pend = 1'b0;
        m_pend_smp = '1;
        m_val = '0;
        m_dv = '0;
        m_seen = '0;
        m_fv = 1'b0;
        m_perr = 1'b0;
        m_edig = '0;
    endtask

    function automatic int zeros(input logic [3:0] a);
        int n = 0;
        for (int i = 0; i < N; i++)
            if (!a[i]) n++;
        return n;
    endfunction

    task automatic apply_accept(input logic [10:0] smp, input logic md);
        logic [3:0] a;
        logic [6:0] s;
        int idx, nib;
        a = smp[10:7];
        s = smp[6:0];
        idx = 0;
        for (int i = 0; i < N; i++)
            if (!a[i]) idx = i;
        nib = -1;
        for (int k = 0; k < 16; k++)
            if (pat[k] == s) nib = k;
        if (s == 7'h7f) begin
            m_val[4*idx +: 4] = 4'h0;
            m_dv[idx] = 1'b0;
        end else if (nib >= 0 && (md || nib < 10)) begin
            m_val[4*idx +: 4] = 4'(nib);
            m_dv[idx] = 1'b1;
        end else begin
            m_perr = 1'b1;
            m_edig = 2'(idx);
        end
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hf) begin
            m_fv = 1'b1;
            m_seen = '0;
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s,
                        input logic md, input logic clr);
        logic [10:0] smp;
        bus.an = a;
        bus.seg = s;
        bus.mode = md;
        bus.clear = clr;
        m_fv = 1'b0;
        if (clr) begin
            m_val = '0;
            m_dv = '0;
            m_seen = '0;
            m_perr = 1'b0;
        end else if (m_pend) begin
            apply_accept(m_pend_smp, md);
        end
        smp = m_pipe[0];
        m_pend = 1'b0;
        if (clr || zeros(smp[10:7]) != 1) begin
            run_len = 0;
        end else if (run_len > 0 && smp == run_val) begin
            if (run_len <= S) run_len++;
            if (run_len == S) begin
                m_pend = 1'b1;
                m_pend_smp = smp;
            end
        end else begin
            run_len = 1;
            run_val = smp;
        end
        m_pipe[0] = m_pipe[1];
        m_pipe[1] = {a, s};
        exp_q.push_back({m_val, m_dv, m_fv, m_perr, m_edig});
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s,
                        input logic md, input int n);
        for (int i = 0; i < n; i++) step(a, s, md, 1'b0);
    endtask

    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {bus.value, bus.digit_valid, bus.frame_valid,
                     bus.pattern_err, bus.err_digit};
                check("cycle", 32'(g), 32'(e));
            end
        end
    end

    initial begin
        logic [3:0] ra;
        logic [6:0] rs;
        logic rm;
        pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        bus.an = '1;
        bus.seg = '1;
        bus.mode = 1'b0;
        bus.clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_state", 32'({bus.value, bus.digit_valid, bus.frame_valid,
              bus.pattern_err, bus.err_digit}), 32'h0);

        hold(4'b1110, pat[3], 1'b0, 6);
        check("latency_edge6", 32'(bus.value), 32'h0);
        hold(4'b1110, pat[3], 1'b0, 1);
        check("static_value", 32'(bus.value), 32'h0003);
        check("static_dv", 32'(bus.digit_valid), 32'h1);
        hold(4'b1110, pat[3], 1'b0, 3);

        for (int sc = 0; sc < 2; sc++) begin
            hold(4'b1110, pat[1], 1'b1, 8);
            hold(4'b1101, pat[2], 1'b1, 8);
            hold(4'b1011, pat[10], 1'b1, 8);
            hold(4'b0111, pat[15], 1'b1, 8);
        end
        check("hex_value", 32'(bus.value), 32'hfa21);
        check("hex_dv", 32'(bus.digit_valid), 32'hf);

        step(4'b0111, pat[15], 1'b0, 1'b1);
        hold(4'b1110, pat[1], 1'b0, 8);
        hold(4'b1101, pat[2], 1'b0, 8);
        hold(4'b1011, pat[10], 1'b0, 8);
        hold(4'b0111, pat[15], 1'b0, 8);
        check("dec_value", 32'(bus.value), 32'h0021);
        check("dec_dv", 32'(bus.digit_valid), 32'h3);
        check("dec_perr", 32'(bus.pattern_err), 32'h1);
        check("dec_edig", 32'(bus.err_digit), 32'h3);

        hold(4'b1110, pat[3], 1'b1, 10);
        hold(4'b1110, pat[8], 1'b1, 3);
        hold(4'b1110, pat[3], 1'b1, 10);
        check("glitch_value", 32'(bus.value), 32'h0023);
        hold(4'b1110, pat[8], 1'b1, 5);
        hold(4'b1111, pat[3], 1'b1, 20);
        check("long8_value", 32'(bus.value), 32'h0028);
        hold(4'b1100, pat[3], 1'b1, 10);
        check("multi_low_idle", 32'(bus.value), 32'h0028);
        hold(4'b1110, 7'b1010101, 1'b1, 8);
        check("bad_pat_edig", 32'({bus.pattern_err, bus.err_digit}), 32'h4);
        check("bad_pat_value", 32'(bus.value), 32'h0028);

        hold(4'b1101, 7'h7f, 1'b1, 10);
        check("blank_value", 32'(bus.value), 32'h0008);
        check("blank_dv", 32'(bus.digit_valid), 32'h1);

        hold(4'b1011, pat[5], 1'b1, 6);
        step(4'b1011, pat[5], 1'b1, 1'b1);
        check("clear_all", 32'({bus.value, bus.digit_valid, bus.frame_valid,
              bus.pattern_err, bus.err_digit}), 32'h0);
        hold(4'b1011, pat[5], 1'b1, 4);
        check("clear_wait", 32'(bus.value), 32'h0);
        hold(4'b1011, pat[5], 1'b1, 1);
        check("reaccept", 32'({bus.value, bus.digit_valid}), 32'h05004);

        hold(4'b0111, pat[7], 1'b1, 3);
        #4;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'({bus.value, bus.digit_valid, bus.frame_valid,
              bus.pattern_err, bus.err_digit}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        hold(4'b1110, pat[3], 1'b0, 7);
        check("post_reset", 32'(bus.value), 32'h0003);

        for (int r = 0; r < 70; r++) begin
            int len, d, k;
            len = $urandom_range(1, 10);
            d = $urandom_range(0, 5);
            if (d < 4) ra = ~(4'b0001 << d);
            else if (d == 4) ra = 4'hf;
            else ra = 4'($urandom);
            k = $urandom_range(0, 9);
            if (k < 7) rs = pat[$urandom_range(0, 15)];
            else if (k == 7) rs = 7'h7f;
            else rs = 7'($urandom);
            rm = 1'($urandom);
            for (int j = 0; j < len; j++)
                step(ra, rs, rm, $urandom_range(0, 40) == 0);
        end

        repeat (2) @(posedge clk);
        #5;
        check("drain", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
